// File: rtl/fifo_byte_serializer.sv
// Reads words from a registered-output FIFO and sends them downstream one byte at a time.
// One LOAD bubble per word; a stalled byte holds until accepted, and the next word is prefetched on the last byte.
module fifo_byte_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = $clog2(NB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16) begin : g_bad_width
    $error("fifo_byte_serializer: DATA_WIDTH must be a multiple of 8 and at least 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [IDXW-1:0]         byte_sel;
  logic [DATA_WIDTH-1:0]   word_shifted;

  assign byte_sel     = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
  assign word_shifted = word_q >> {byte_sel, 3'b000};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    fifo_rd_en = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    tx_data    = 8'h00;

    case (state_q)
      IDLE: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        word_d  = fifo_dout;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = word_shifted[7:0];
        tx_last  = (idx_q == LAST_IDX);
        if (tx_ready) begin
          if (tx_last) begin
            cnt_d = cnt_q + 16'd1;
            // Prefetch the next word on the final byte so only one bubble separates words.
            if (!fifo_empty) begin
              fifo_rd_en = 1'b1;
              state_d    = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      fifo_rd_en = 1'b0;
      tx_valid   = 1'b0;
      tx_last    = 1'b0;
      tx_data    = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE) && !rst;
  assign words_sent = cnt_q;

endmodule

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, FIFO word width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter MSB_FIRST, default 1, byte order: 1 sends the most-significant byte first, 0 sends the least-significant byte first.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 fifo_dout  input  DATA_WIDTH  upstream FIFO registered read data; valid the cycle after fifo_rd_en is sampled high.
REQ-008 tx_data  output  8  byte presented downstream.
REQ-009 tx_valid  output  1  tx_data is valid.
REQ-010 tx_ready  input  1  downstream accepts the byte.
REQ-011 tx_last  output  1  current byte is the final byte of its word.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 words_sent  output  16  count of words fully transmitted.

Function
REQ-014 NB = DATA_WIDTH/8 bytes per word; byte index counter width = clog2(NB).
REQ-015 FSM states: IDLE, LOAD, SEND; IDLE is the reset state.
REQ-016 IDLE: fifo_rd_en = !fifo_empty (combinational); if fifo_rd_en, next state LOAD, else stay IDLE.
REQ-017 LOAD: fifo_rd_en = 0; capture fifo_dout into the word register; clear the byte index to 0; next state SEND.
REQ-018 SEND: tx_valid = 1; tx_data = byte[idx] when MSB_FIRST=0, and byte[NB-1-idx] when MSB_FIRST=1 (byte[0] = bits 7:0).
REQ-019 tx_last = 1 exactly when state is SEND and idx == NB-1.
REQ-020 Handshake: a byte transfers on a cycle with tx_valid && tx_ready.
REQ-021 While tx_valid && !tx_ready, tx_data, tx_last and idx SHALL hold stable; tx_valid SHALL NOT drop before the transfer completes.
REQ-022 On a non-last transfer, idx increments by 1 and the state stays SEND.
REQ-023 On a last transfer, words_sent increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-024 On a last transfer, if fifo_empty == 0: fifo_rd_en = 1 in that same cycle and the next state is LOAD (back-to-back prefetch).
REQ-025 On a last transfer, if fifo_empty == 1: the next state is IDLE.
REQ-026 fifo_rd_en SHALL be asserted only in the cases of REQ-016 and REQ-024, and never while fifo_empty == 1.
REQ-027 Steady-state throughput with tx_ready held high and the FIFO non-empty: NB bytes per NB+1 cycles (one LOAD bubble per word).
REQ-028 tx_valid = 0 in IDLE and LOAD; tx_data = 8'h00 whenever tx_valid = 0.
REQ-029 A word read from the FIFO SHALL always be transmitted in full unless rst intervenes; no byte is duplicated or skipped.

Reset
REQ-030 When rst is high at a rising edge: state <= IDLE, idx <= 0, word register <= 0, words_sent <= 0.
REQ-031 While rst is high, fifo_rd_en = 0, tx_valid = 0, tx_last = 0, busy = 0 and tx_data = 8'h00, overriding the FSM.
REQ-032 Reset mid-word discards the remaining bytes of that word; the next word transmitted after reset starts at idx 0.
REQ-033 Assertion of rst SHALL NOT generate a FIFO read.

Verification
REQ-034 Single word (DATA_WIDTH=32, MSB_FIRST=1): FIFO holds 0xA1B2C3D4, tx_ready=1 -> bytes A1, B2, C3, D4 on consecutive cycles; tx_last only on D4; words_sent=1; return to IDLE.
REQ-035 Byte order: MSB_FIRST=0 with word 0x11223344 -> bytes 44, 33, 22, 11.
REQ-036 Backpressure: tx_ready low for 5 cycles during byte 2 -> tx_data holds that byte, tx_valid stays 1, no fifo_rd_en pulse; the sequence resumes intact.
REQ-037 Back-to-back: 3 words queued, tx_ready=1 -> exactly 3 fifo_rd_en pulses, 12 bytes in 15 cycles, fifo_rd_en coincident with each tx_last while the FIFO is non-empty, words_sent=3.
REQ-038 Empty FIFO: fifo_empty=1 for 20 cycles -> fifo_rd_en, tx_valid and busy all stay 0.
REQ-039 Reset mid-word: assert rst after byte 2 of 0xDEADBEEF -> outputs return to their reset values; the next queued word 0x01020304 is sent as 01, 02, 03, 04; words_sent restarts from 0.
